jk_bank_sched: RTL and testbench

JK_BANK_SCHED -- requirements
Module: jk_bank_sched

---
 rtl/jk_bank_sched.sv | 127 ++++++++++++
 tb/tb_jk_bank_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_sched.sv
// jk_bank_sched: two-requester arbiter that drives a bank of JK flip-flops.
// A granted command applies one JK op to one bank bit rpt+1 times, then
// pulses done and hands priority to the requester that was not served.

// One bank bit: a JK flip-flop that only changes when enabled.
module jk_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);
    // JK update: 01 clears, 10 sets, 11 toggles, 00 holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (en) begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end
endmodule

module jk_bank_sched #(
    parameter  int N_FF  = 4,
    parameter  int RPT_W = 4,
    localparam int SEL_W = (N_FF > 1) ? $clog2(N_FF) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [1:0]       req0_op,
    input  logic [1:0]       req1_op,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic [SEL_W-1:0] req1_sel,
    input  logic [RPT_W-1:0] req0_rpt,
    input  logic [RPT_W-1:0] req1_rpt,
    output logic [N_FF-1:0]  q,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    state_t             state, nstate;
    logic [1:0]         op_r;
    logic [SEL_W-1:0]   sel_r;
    logic [RPT_W-1:0]   cnt;
    logic               fin;     // cnt reached 0 and its final application is done
    logic               prio;    // 1: requester 1 wins a tie
    logic               w1;      // requester 1 wins this cycle
    logic               hs;
    logic               apply_en;

    // Arbitration: a lone valid wins, ties go to prio; nothing accepted outside IDLE or in reset
    always_comb begin
        w1         = req1_valid && (!req0_valid || prio);
        req1_ready = rst_n && (state == IDLE) && w1;
        req0_ready = rst_n && (state == IDLE) && req0_valid && !w1;
        hs         = req0_ready || req1_ready;
    end

    // Next-state: one extra APPLY cycle after the last application before DONE
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (hs) nstate = APPLY;
            APPLY:   if (cnt == '0 && fin) nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    // Command capture, repeat counter, grant and priority bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r  <= 2'b00;
            sel_r <= '0;
            cnt   <= '0;
            fin   <= 1'b0;
            prio  <= 1'b0;
            grant <= 2'b00;
        end else if (hs) begin
            op_r  <= w1 ? req1_op  : req0_op;
            sel_r <= w1 ? req1_sel : req0_sel;
            cnt   <= w1 ? req1_rpt : req0_rpt;
            fin   <= 1'b0;
            grant <= w1 ? 2'b10 : 2'b01;
        end else if (apply_en) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
            else           fin <= 1'b1;
        end else if (state == DONE) begin
            prio  <= grant[0];   // served req0 -> favour req1 next, and vice versa
            grant <= 2'b00;
        end
    end

    assign apply_en = (state == APPLY) && !fin;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // Bank bits; an out-of-range sel matches no cell and leaves q untouched
    for (genvar i = 0; i < N_FF; i++) begin : g_ff
        jk_cell u_ff (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (apply_en && (sel_r == SEL_W'(i))),
            .j     (op_r[1]),
            .k     (op_r[0]),
            .q     (q[i])
        );
    end
endmodule

// File: tb/tb_jk_bank_sched.sv
// Directed bench for jk_bank_sched: set/reset, repeat toggle, arbitration,
// reset abort, max repeat and out-of-range select (N_FF=3 instance).
module tb_jk_bank_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 0, req1_valid = 0;
    logic       req0_ready, req1_ready;
    logic [1:0] req0_op = 0, req1_op = 0;
    logic [1:0] req0_sel = 0, req1_sel = 0;
    logic [3:0] req0_rpt = 0, req1_rpt = 0;
    logic [3:0] q;
    logic [1:0] grant;
    logic       busy, done;

    logic       c_r0v = 0, c_r1v = 0, c_r0rdy, c_r1rdy;
    logic [1:0] c_r0op = 0, c_r1op = 0, c_r0sel = 0, c_r1sel = 0;
    logic [3:0] c_r0rpt = 0, c_r1rpt = 0;
    logic [2:0] c_q;
    logic [1:0] c_grant;
    logic       c_busy, c_done;

    int n_chk = 0, n_pass = 0;
    int bc, dc, gi;
    logic pb;
    logic [1:0] gr [4];

    always #5 clk = ~clk;

    jk_bank_sched #(.N_FF(4), .RPT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_sel(req0_sel), .req1_sel(req1_sel),
        .req0_rpt(req0_rpt), .req1_rpt(req1_rpt),
        .q(q), .grant(grant), .busy(busy), .done(done)
    );

    jk_bank_sched #(.N_FF(3), .RPT_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(c_r0v), .req1_valid(c_r1v),
        .req0_ready(c_r0rdy), .req1_ready(c_r1rdy),
        .req0_op(c_r0op), .req1_op(c_r1op),
        .req0_sel(c_r0sel), .req1_sel(c_r1sel),
        .req0_rpt(c_r0rpt), .req1_rpt(c_r1rpt),
        .q(c_q), .grant(c_grant), .busy(c_busy), .done(c_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present a command, wait (bounded) for ready, take the handshake edge, drop valid.
    task automatic issue(input logic r, input logic [1:0] op, input logic [1:0] sel,
                         input logic [3:0] rpt);
        int w;
        if (r) begin req1_op = op; req1_sel = sel; req1_rpt = rpt; req1_valid = 1'b1; end
        else   begin req0_op = op; req0_sel = sel; req0_rpt = rpt; req0_valid = 1'b1; end
        #1;
        w = 0;
        while (!(r ? req1_ready : req0_ready) && w < 20) begin
            tick();
            w++;
        end
        if (w == 20) chk("hs_timeout", 0, 1);
        tick();
        if (r) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
    endtask

    initial begin
        // Reset state, with a valid request that must not be accepted
        req0_valid = 1'b1;
        #2;
        chk("rst_q", q, 4'b0000);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_grant", grant, 2'b00);
        chk("rst_ready0", req0_ready, 0);
        req0_valid = 1'b0;
        do_reset();

        // Set bit 2, then reset it (req0)
        issue(0, 2'b10, 2'd2, 4'd0);
        chk("set_busy", busy, 1);
        chk("set_grant", grant, 2'b01);
        tick();
        chk("set_q", q, 4'b0100);
        chk("set_done_early", done, 0);
        tick();
        chk("set_done", done, 1);
        tick();
        chk("set_done_clr", done, 0);
        chk("set_idle", busy, 0);
        chk("set_grant_clr", grant, 2'b00);
        issue(0, 2'b01, 2'd2, 4'd0);
        tick();
        chk("clr_q", q, 4'b0000);
        tick();
        chk("clr_done", done, 1);
        tick();

        // Lone req1 with prio=0, toggle bit 0 five times
        do_reset();
        req1_op = 2'b11; req1_sel = 2'd0; req1_rpt = 4'd4; req1_valid = 1'b1;
        #1;
        chk("solo_ready1", req1_ready, 1);
        issue(1, 2'b11, 2'd0, 4'd4);
        chk("tog_grant", grant, 2'b10);
        bc = busy; dc = 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (k < 5) chk("tog_q", q, (k % 2 == 0) ? 4'b0001 : 4'b0000);
            bc += busy;
            dc += done;
        end
        chk("tog_busy_cycles", bc, 7);
        chk("tog_done_cnt", dc, 1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("prio_back_0", {req1_ready, req0_ready}, 2'b01);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Arbitration: both valid continuously, toggles on distinct bits
        do_reset();
        req0_op = 2'b11; req0_sel = 2'd0; req0_rpt = 4'd0;
        req1_op = 2'b11; req1_sel = 2'd1; req1_rpt = 4'd0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        gi = 0; pb = 1'b0;
        for (int c = 0; c < 40 && gi < 4; c++) begin
            tick();
            if (busy && !pb) begin
                gr[gi] = grant;
                if (gi == 2) chk("arb_q_mid", q, 4'b0011);
                gi++;
            end
            pb = busy;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("arb_count", gi, 4);
        chk("arb_g0", gr[0], 2'b01);
        chk("arb_g1", gr[1], 2'b10);
        chk("arb_g2", gr[2], 2'b01);
        chk("arb_g3", gr[3], 2'b10);
        for (int c = 0; c < 10 && busy; c++) tick();
        chk("arb_q_end", q, 4'b0000);

        // Reset during the 3rd APPLY cycle of an rpt=7 toggle
        do_reset();
        issue(0, 2'b10, 2'd3, 4'd0);
        tick(); tick(); tick();
        chk("pre_q", q, 4'b1000);
        issue(0, 2'b11, 2'd1, 4'd7);
        tick();
        chk("abort_q1", q, 4'b1010);
        tick();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        #1;
        chk("abort_q", q, 4'b0000);
        chk("abort_busy", busy, 0);
        chk("abort_grant", grant, 2'b00);
        chk("abort_ready", req0_ready, 0);
        dc = done;
        tick(); tick();
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            dc += done;
        end
        chk("abort_no_done", dc, 0);
        issue(1, 2'b10, 2'd1, 4'd0);
        tick();
        chk("post_rst_q", q, 4'b0010);
        tick();
        chk("post_rst_done", done, 1);
        tick();

        // Max repeat: 16 toggles of bit 2 -> back to 0, busy for 18 cycles
        do_reset();
        issue(0, 2'b11, 2'd2, 4'd15);
        bc = busy; dc = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (k == 0) chk("max_q_first", q, 4'b0100);
            bc += busy;
            dc += done;
        end
        chk("max_busy_cycles", bc, 18);
        chk("max_done_cnt", dc, 1);
        chk("max_q_end", q, 4'b0000);

        // N_FF=3: set bit 1, then sel=3 must not touch q but keep timing
        c_r0op = 2'b10; c_r0sel = 2'd1; c_r0rpt = 4'd0; c_r0v = 1'b1;
        #1;
        chk("oor_ready", c_r0rdy, 1);
        tick();
        c_r0v = 1'b0;
        tick(); tick(); tick();
        chk("oor_pre_q", c_q, 3'b010);
        c_r0sel = 2'd3; c_r0v = 1'b1;
        tick();
        c_r0v = 1'b0;
        chk("oor_busy", c_busy, 1);
        tick();
        chk("oor_q", c_q, 3'b010);
        chk("oor_done_early", c_done, 0);
        tick();
        chk("oor_done", c_done, 1);
        tick();
        chk("oor_idle", c_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
